exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception/interrupt arbiter for the pipelined MIPS core, sitting between the MEM stage and the CP0 register file. It collects per-instruction exception flags and synchronized external and timer interrupts, and checks them against forwarded Status/Cause/EPC. It then emits the single `excepttype` code, faulting PC and delay-slot flag that CP0 commits, and sequences the pipeline flush and redirect to the vector or EPC.

## Interface
- `EXC_VECTOR`, default `32'h0000_0020`: redirect target for every exception except eret.
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-high; clock clk.
- `int_i  in  8`: raw external interrupt lines, asynchronous.
- `time_int_i  in  1`: CP0 compare-match interrupt.
- `mem_valid  in  1`: the MEM-stage instruction is real, not a bubble.
- `mem_pc  in  32`: MEM-stage instruction address.
- `mem_in_delay_slot  in  1`: the MEM-stage instruction is in a branch delay slot.
- `mem_syscall`, `mem_ri`, `mem_ov`, `mem_trap`, `mem_eret`  in  1 each: exception flags.
- `mem_cp0_we  in  1`, `mem_cp0_waddr  in  5`, `mem_cp0_wdata  in  32`: pending mtc0 in MEM.
- `cp0_status_i`, `cp0_cause_i`, `cp0_epc_i`  in  32 each: current CP0 registers.
- `excepttype_o  out  32`: exception code to CP0.
- `current_inst_addr_o  out  32`: faulting PC to CP0.
- `is_in_delay_slot_o  out  1`: delay-slot flag to CP0.
- `cp0_int_o  out  8`: synchronized interrupt lines to CP0 `int_i`.
- `flush_o  out  1`: flush IF/ID/EX/MEM.
- `new_pc_o  out  32`: redirect target, valid while `flush_o` is high.
- `stall_o  out  1`: freeze PC and pipeline.

## Operation
- **Forwarding.** Effective Status/Cause/EPC equal `mem_cp0_wdata` when `mem_cp0_we` is high and `waddr` is 12/13/14 respectively. Otherwise they are the `cp0_*_i` values.
- **Interrupt lines.** `int_i` passes through a 2-flop synchronizer, giving `sync_int`. `cp0_int_o` = `sync_int`, with bit 7 ORed with `time_int_i` (see Configuration).
- **Interrupt pending.** Asserted when Status.IE[0]=1, Status.EXL[1]=0, and (Status.IM[15:8] & (Cause.IP[15:8] | `cp0_int_o`)) != 0.
- **Priority and codes** (first match wins): interrupt 0x1, ri 0xa, ov 0xb, trap 0xc, syscall 0x9, eret 0xd. No match gives 0x0.
- **Qualification.** Codes are evaluated only when state=IDLE and `mem_valid`=1. Otherwise `excepttype_o`=0.
- `current_inst_addr_o` = `mem_pc` and `is_in_delay_slot_o` = `mem_in_delay_slot`; both are combinational.
- **FSM.**
  - IDLE: on a nonzero code, latch the target and go to FLUSH. The target is effective EPC for eret and `EXC_VECTOR` for all other codes.
  - FLUSH: `flush_o`=1, `stall_o`=1, `new_pc_o`=target. Always go to DRAIN.
  - DRAIN: `stall_o`=1, so the CP0 EXL/EPC update becomes visible. Always go to IDLE.
- Exceptions presented during FLUSH or DRAIN are ignored; the flush squashes them.

## Timing
- **Reset values.** state=IDLE; synchronizer=0; `flush_o`=0, `stall_o`=0, `new_pc_o`=0, `cp0_int_o`=0, `excepttype_o`=0.
- `excepttype_o` is combinational in the detect cycle T. CP0 commits it at edge T+1.
- `flush_o` and `new_pc_o` are high for exactly cycle T+1. `stall_o` is high in cycles T+1 and T+2. A new exception can be accepted from cycle T+3.
- **Interrupt latency.** An `int_i` edge reaches `cp0_int_o` 2 cycles later.
- **Reset mid-sequence.** Reset returns the FSM to IDLE on the next edge. `flush_o`/`stall_o` drop on that edge and the latched target is discarded.
- **Back-to-back.** After an exception flush, the earliest next code is seen at T+3.

## Configuration
- **`EXC_TIMER_INT_EN` defined:** `time_int_i` is ORed into `cp0_int_o[7]`.
- **`EXC_TIMER_INT_EN` undefined:**
  - `time_int_i` is ignored.
  - `cp0_int_o[7]` = `sync_int[7]` only.
  - The compare-match interrupt can never fire.

## Test plan
- **ri:** `mem_valid`=1, `mem_ri`=1, `mem_pc`=0x100 -> `excepttype_o`=0xa, addr=0x100 in T; `flush_o`=1, `new_pc_o`=0x20 in T+1; `stall_o`=1 in T+1 and T+2.
- **Delay slot + priority:** `mem_in_delay_slot`=1 with ov and syscall both high -> code 0xb and `is_in_delay_slot_o`=1.
- **eret with forwarded EPC:** eret with `mem_cp0_we`=1, waddr=14, wdata=0x400, `cp0_epc_i`=0x300 -> code 0xd, `new_pc_o`=0x400.
- **Interrupt masking:**
  - `int_i[2]`=1, Status=0x1000_0401 -> code 0x1 two cycles later.
  - Same stimulus with EXL=1 (Status=0x1000_0403) -> code stays 0.
- **Timer interrupt and back-to-back:**
  - Timer with Status=0x1000_8001 -> 0x1 when the macro is defined, 0 when undefined.
  - Two consecutive syscall instructions -> only the first produces 0x9.
- **Reset mid-sequence:** reset asserted in the FLUSH cycle -> next cycle `flush_o`=`stall_o`=0 and `cp0_int_o`=0.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter between MEM and CP0: prioritises exception codes and sequences flush/redirect.
// Optional EXC_TIMER_INT_EN: ORs time_int_i into cp0_int_o[7].
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  int_i,
  input  logic        time_int_i,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delay_slot,
  input  logic        mem_syscall,
  input  logic        mem_ri,
  input  logic        mem_ov,
  input  logic        mem_trap,
  input  logic        mem_eret,
  input  logic        mem_cp0_we,
  input  logic [4:0]  mem_cp0_waddr,
  input  logic [31:0] mem_cp0_wdata,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delay_slot_o,
  output logic [7:0]  cp0_int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [7:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_pending;
  logic [31:0] exc_code;
  logic [45:0] unused_cp0_bits;

  // An mtc0 still in MEM has not reached CP0 yet, so its value wins.
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (mem_cp0_we && mem_cp0_waddr == 5'd12) status_eff = mem_cp0_wdata;
    if (mem_cp0_we && mem_cp0_waddr == 5'd13) cause_eff  = mem_cp0_wdata;
    if (mem_cp0_we && mem_cp0_waddr == 5'd14) epc_eff    = mem_cp0_wdata;
  end

  assign unused_cp0_bits = {status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

`ifdef EXC_TIMER_INT_EN
  assign cp0_int_o = {sync2_q[7] | time_int_i, sync2_q[6:0]};
`else
  logic unused_time_int;
  assign unused_time_int = time_int_i;
  assign cp0_int_o = sync2_q;
`endif

  assign int_pending = status_eff[0] & ~status_eff[1]
                     & (|(status_eff[15:8] & (cause_eff[15:8] | cp0_int_o)));

  always_comb begin
    exc_code = 32'h0;
    if (state_q == S_IDLE && mem_valid) begin
      if      (int_pending) exc_code = 32'h1;
      else if (mem_ri)      exc_code = 32'ha;
      else if (mem_ov)      exc_code = 32'hb;
      else if (mem_trap)    exc_code = 32'hc;
      else if (mem_syscall) exc_code = 32'h9;
      else if (mem_eret)    exc_code = 32'hd;
    end
  end

  assign excepttype_o        = exc_code;
  assign current_inst_addr_o = mem_pc;
  assign is_in_delay_slot_o  = mem_in_delay_slot;

  assign sync1_d = int_i;
  assign sync2_d = sync1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= 32'h0;
      sync1_q  <= 8'h0;
      sync2_q  <= 8'h0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (exc_code != 32'h0) begin
          state_d  = S_FLUSH;
          target_d = (exc_code == 32'hd) ? epc_eff : EXC_VECTOR;
        end
      end
      S_FLUSH: state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // DRAIN keeps the pipeline frozen one extra cycle so CP0's EXL/EPC update is visible.
  always_comb begin
    flush_o  = 1'b0;
    stall_o  = 1'b0;
    new_pc_o = 32'h0;
    case (state_q)
      S_FLUSH: begin
        flush_o  = 1'b1;
        stall_o  = 1'b1;
        new_pc_o = target_q;
      end
      S_DRAIN: stall_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed and randomized bench for exc_ctrl against a cycle-level reference model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  int_i;
  logic        time_int_i;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delay_slot;
  logic        mem_syscall, mem_ri, mem_ov, mem_trap, mem_eret;
  logic        mem_cp0_we;
  logic [4:0]  mem_cp0_waddr;
  logic [31:0] mem_cp0_wdata;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
  logic        is_in_delay_slot_o, flush_o, stall_o;
  logic [7:0]  cp0_int_o;

  int errors = 0;
  int checks = 0;

  // Reference model: busy counts remaining redirect cycles (2 = flushing, 1 = draining).
  int          busy = 0;
  logic [31:0] tgt = 32'h0;
  logic [7:0]  int_q[$] = '{8'h0, 8'h0};
  logic [31:0] exp_code;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .int_i(int_i), .time_int_i(time_int_i),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_in_delay_slot(mem_in_delay_slot),
    .mem_syscall(mem_syscall), .mem_ri(mem_ri), .mem_ov(mem_ov), .mem_trap(mem_trap),
    .mem_eret(mem_eret), .mem_cp0_we(mem_cp0_we), .mem_cp0_waddr(mem_cp0_waddr),
    .mem_cp0_wdata(mem_cp0_wdata), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .excepttype_o(excepttype_o),
    .current_inst_addr_o(current_inst_addr_o), .is_in_delay_slot_o(is_in_delay_slot_o),
    .cp0_int_o(cp0_int_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_o(stall_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_int();
    logic [7:0] v;
    v = int_q[0];
`ifdef EXC_TIMER_INT_EN
    if (time_int_i) v = v | 8'h80;
`endif
    return v;
  endfunction

  function automatic logic [31:0] eff(input int addr, input logic [31:0] reg_val);
    if (mem_cp0_we && int'(mem_cp0_waddr) == addr) return mem_cp0_wdata;
    return reg_val;
  endfunction

  function automatic logic [31:0] ref_code();
    logic [31:0] st, ca;
    logic pend;
    if (busy != 0 || !mem_valid) return 32'h0;
    st = eff(12, cp0_status_i);
    ca = eff(13, cp0_cause_i);
    pend = st[0] && !st[1] && ((st[15:8] & (ca[15:8] | ref_int())) != 8'h0);
    if (pend)        return 32'h1;
    if (mem_ri)      return 32'ha;
    if (mem_ov)      return 32'hb;
    if (mem_trap)    return 32'hc;
    if (mem_syscall) return 32'h9;
    if (mem_eret)    return 32'hd;
    return 32'h0;
  endfunction

  // Check every output for the current cycle, then advance DUT and model one clock.
  task automatic cyc();
    #1;
    exp_code = ref_code();
    chk("excepttype", excepttype_o, exp_code);
    chk("inst_addr", current_inst_addr_o, mem_pc);
    chk("delay_slot", {31'h0, is_in_delay_slot_o}, {31'h0, mem_in_delay_slot});
    chk("cp0_int", {24'h0, cp0_int_o}, {24'h0, ref_int()});
    chk("flush", {31'h0, flush_o}, {31'h0, busy == 2});
    chk("stall", {31'h0, stall_o}, {31'h0, busy != 0});
    chk("new_pc", new_pc_o, (busy == 2) ? tgt : 32'h0);
    @(posedge clk);
    if (reset) begin
      busy = 0;
      tgt = 32'h0;
      int_q = '{8'h0, 8'h0};
    end else begin
      int_q.push_back(int_i);
      void'(int_q.pop_front());
      if (busy != 0) busy--;
      else if (exp_code != 32'h0) begin
        busy = 2;
        tgt = (exp_code == 32'hd) ? eff(14, cp0_epc_i) : 32'h0000_0020;
      end
    end
    @(negedge clk);
  endtask

  task automatic clr();
    mem_valid = 1'b0; mem_in_delay_slot = 1'b0;
    mem_syscall = 1'b0; mem_ri = 1'b0; mem_ov = 1'b0; mem_trap = 1'b0; mem_eret = 1'b0;
    mem_cp0_we = 1'b0; mem_cp0_waddr = 5'd0; mem_cp0_wdata = 32'h0;
  endtask

  initial begin
    reset = 1'b1; int_i = 8'h0; time_int_i = 1'b0; mem_pc = 32'h0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    clr();
    @(negedge clk);
    cyc(); cyc();
    chk("rst_flush", {31'h0, flush_o}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_new_pc", new_pc_o, 32'h0);
    chk("rst_cp0_int", {24'h0, cp0_int_o}, 32'h0);
    reset = 1'b0;
    cyc();

    // ri with vector redirect
    mem_valid = 1'b1; mem_ri = 1'b1; mem_pc = 32'h100;
    #1 chk("ri_code", excepttype_o, 32'ha);
    chk("ri_addr", current_inst_addr_o, 32'h100);
    cyc();
    clr(); mem_valid = 1'b1; mem_syscall = 1'b1;
    #1 chk("ri_flush", {31'h0, flush_o}, 32'h1);
    chk("ri_new_pc", new_pc_o, 32'h20);
    chk("ri_squashed", excepttype_o, 32'h0);
    cyc();
    #1 chk("ri_drain_stall", {31'h0, stall_o}, 32'h1);
    cyc();
    clr(); cyc();

    // delay slot with ov outranking syscall
    mem_valid = 1'b1; mem_in_delay_slot = 1'b1; mem_ov = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h204;
    #1 chk("ds_code", excepttype_o, 32'hb);
    chk("ds_flag", {31'h0, is_in_delay_slot_o}, 32'h1);
    cyc(); clr(); cyc(); cyc();

    // eret with forwarded EPC
    mem_valid = 1'b1; mem_eret = 1'b1; cp0_epc_i = 32'h300;
    mem_cp0_we = 1'b1; mem_cp0_waddr = 5'd14; mem_cp0_wdata = 32'h400;
    #1 chk("eret_code", excepttype_o, 32'hd);
    cyc(); clr();
    #1 chk("eret_new_pc", new_pc_o, 32'h400);
    cyc(); cyc();

    // interrupt through the synchronizer
    mem_valid = 1'b1; cp0_status_i = 32'h1000_0401; int_i = 8'h04;
    cyc(); cyc();
    #1 chk("irq_code", excepttype_o, 32'h1);
    cyc(); cyc(); cyc();
    int_i = 8'h00; mem_valid = 1'b0;
    cyc(); cyc(); cyc();
    mem_valid = 1'b1; cp0_status_i = 32'h1000_0403; int_i = 8'h04;
    for (int i = 0; i < 4; i++) cyc();
    #1 chk("irq_exl_masked", excepttype_o, 32'h0);
    int_i = 8'h00; cyc(); cyc(); cyc();

    // timer interrupt
    cp0_status_i = 32'h1000_8001; time_int_i = 1'b1;
`ifdef EXC_TIMER_INT_EN
    #1 chk("timer_code", excepttype_o, 32'h1);
`else
    #1 chk("timer_code", excepttype_o, 32'h0);
`endif
    cyc();
    time_int_i = 1'b0; cp0_status_i = 32'h0; clr(); cyc(); cyc(); cyc();

    // back-to-back syscalls
    mem_valid = 1'b1; mem_syscall = 1'b1;
    #1 chk("b2b_first", excepttype_o, 32'h9);
    cyc();
    #1 chk("b2b_second", excepttype_o, 32'h0);
    cyc(); clr(); cyc(); cyc();

    // reset during FLUSH
    int_i = 8'hff;
    cyc(); cyc();
    mem_valid = 1'b1; mem_trap = 1'b1;
    #1 chk("rst_mid_code", excepttype_o, 32'hc);
    cyc(); clr();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1 chk("rst_mid_flush", {31'h0, flush_o}, 32'h0);
    chk("rst_mid_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_mid_cp0_int", {24'h0, cp0_int_o}, 32'h0);
    cyc(); cyc(); cyc();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] st;
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) int_i = 8'($urandom);
      time_int_i = ($urandom_range(0, 3) == 0);
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_pc = $urandom & 32'hffff_fffc;
      mem_in_delay_slot = 1'($urandom);
      mem_syscall = ($urandom_range(0, 7) == 0);
      mem_ri = ($urandom_range(0, 9) == 0);
      mem_ov = ($urandom_range(0, 9) == 0);
      mem_trap = ($urandom_range(0, 9) == 0);
      mem_eret = ($urandom_range(0, 7) == 0);
      mem_cp0_we = ($urandom_range(0, 3) == 0);
      mem_cp0_waddr = ($urandom_range(0, 1) == 0) ? 5'(12 + $urandom_range(0, 2)) : 5'($urandom);
      mem_cp0_wdata = $urandom;
      st = $urandom;
      if ($urandom_range(0, 1) == 0) st[1] = 1'b0;
      st[0] = ($urandom_range(0, 3) != 0);
      cp0_status_i = st;
      cp0_cause_i = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      cp0_epc_i = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
